// File: rtl/hazard_stall_control_pkg.sv
// core_pkg: shared opcodes, hazard FSM state encoding and load-stall limits.
package core_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, LOAD_STALL = 2'd1, MEM_WAIT = 2'd2} hazard_state_e;
  localparam int LSC_MIN = 1;
  localparam int LSC_MAX = 3;
  localparam int LSC_CW = $clog2(LSC_MAX);
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
endpackage

// File: rtl/hazard_stall_control_if.sv
// hazard_stall_control_if: pipeline hazard inputs and stall/flush controls.
interface hazard_stall_control_if;
  logic [6:0]  if_id_opcode_ip;
  logic [4:0]  if_id_rs1_ip;
  logic [4:0]  if_id_rs2_ip;
  logic        id_ex_mem_read_ip;
  logic [4:0]  id_ex_dest_ip;
  logic        ex_branch_taken_ip;
  logic        mem_busy_ip;
  logic        pc_write_en_op;
  logic        if_id_write_en_op;
  logic        id_ex_write_en_op;
  logic        ex_mem_write_en_op;
  logic        if_id_flush_op;
  logic        id_ex_bubble_op;
  logic [1:0]  hazard_state_op;
  logic [31:0] stall_count_op;
  logic [31:0] flush_count_op;
  modport master (
    output if_id_opcode_ip, if_id_rs1_ip, if_id_rs2_ip, id_ex_mem_read_ip, id_ex_dest_ip,
           ex_branch_taken_ip, mem_busy_ip,
    input  pc_write_en_op, if_id_write_en_op, id_ex_write_en_op, ex_mem_write_en_op,
           if_id_flush_op, id_ex_bubble_op, hazard_state_op, stall_count_op, flush_count_op
  );
  modport slave (
    input  if_id_opcode_ip, if_id_rs1_ip, if_id_rs2_ip, id_ex_mem_read_ip, id_ex_dest_ip,
           ex_branch_taken_ip, mem_busy_ip,
    output pc_write_en_op, if_id_write_en_op, id_ex_write_en_op, ex_mem_write_en_op,
           if_id_flush_op, id_ex_bubble_op, hazard_state_op, stall_count_op, flush_count_op
  );
endinterface

// File: rtl/hazard_stall_control_rs_usage.sv
// hazard_rs_usage: decodes which source register fields an opcode actually reads.
module hazard_rs_usage
  import core_pkg::*;
(
  input  logic [6:0] opcode_ip,
  output logic       rs1_used_op,
  output logic       rs2_used_op
);
  always_comb begin
    rs2_used_op = opcode_ip inside {OPCODE_OP, OPCODE_STORE, OPCODE_BRANCH};
    rs1_used_op = rs2_used_op || (opcode_ip inside {OPCODE_OPIMM, OPCODE_LOAD, OPCODE_JALR});
  end
endmodule

// File: rtl/hazard_stall_control.sv
// hazard_stall_control: load-use stall, branch flush and memory-wait freeze controller.
module hazard_stall_control
  import core_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  hazard_stall_control_if.slave  hs
);
  logic              w_rs1_used, w_rs2_used, w_load_use;
  logic              w_pc_we, w_ifid_we, w_idex_we, w_exmem_we, w_flush, w_bubble;
  hazard_state_e     r_state, w_state, w_next;
  logic [LSC_CW-1:0] r_cnt, w_cnt_next;
  logic [31:0]       r_stall_cnt, r_flush_cnt;
  hazard_rs_usage u_rs_usage (
    .opcode_ip   (hs.if_id_opcode_ip),
    .rs1_used_op (w_rs1_used),
    .rs2_used_op (w_rs2_used)
  );
  assign w_load_use = hs.id_ex_mem_read_ip && hs.id_ex_dest_ip != 5'd0 &&
                      ((w_rs1_used && hs.id_ex_dest_ip == hs.if_id_rs1_ip) ||
                       (w_rs2_used && hs.id_ex_dest_ip == hs.if_id_rs2_ip));
  // While reset is held the controller behaves as if already in RUN.
  always_comb begin
    w_state    = reset ? RUN : r_state;
    w_pc_we    = 1'b1;
    w_ifid_we  = 1'b1;
    w_idex_we  = 1'b1;
    w_exmem_we = 1'b1;
    w_flush    = 1'b0;
    w_bubble   = 1'b0;
    w_next     = RUN;
    w_cnt_next = r_cnt;
    if (hs.mem_busy_ip) begin
      w_pc_we    = 1'b0;
      w_ifid_we  = 1'b0;
      w_idex_we  = 1'b0;
      w_exmem_we = 1'b0;
      w_next     = (w_state == LOAD_STALL) ? LOAD_STALL : MEM_WAIT;
    end else if (hs.ex_branch_taken_ip) begin
      w_flush    = 1'b1;
      w_bubble   = 1'b1;
      w_cnt_next = '0;
    end else if (w_state == LOAD_STALL || w_load_use) begin
      w_pc_we   = 1'b0;
      w_ifid_we = 1'b0;
      w_bubble  = 1'b1;
      if (w_state == LOAD_STALL) begin
        w_next     = (r_cnt == LSC_CW'(1)) ? RUN : LOAD_STALL;
        w_cnt_next = r_cnt - LSC_CW'(1);
      end else if (LOAD_STALL_CYCLES > 1) begin
        w_next     = LOAD_STALL;
        w_cnt_next = LSC_CW'(LOAD_STALL_CYCLES - 1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= RUN;
      r_cnt       <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (!w_pc_we && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_flush && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end
  assign hs.pc_write_en_op     = w_pc_we;
  assign hs.if_id_write_en_op  = w_ifid_we;
  assign hs.id_ex_write_en_op  = w_idex_we;
  assign hs.ex_mem_write_en_op = w_exmem_we;
  assign hs.if_id_flush_op     = w_flush;
  assign hs.id_ex_bubble_op    = w_bubble;
  assign hs.hazard_state_op    = w_state;
  assign hs.stall_count_op     = r_stall_cnt;
  assign hs.flush_count_op     = r_flush_cnt;
endmodule

// File: tb/tb_hazard_stall_control.sv
// tb_hazard_stall_control: directed and random checks of two instances (1 and 3 stall cycles).
module tb_hazard_stall_control;
  import core_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] op = OPCODE_LUI;
  logic [4:0] rs1 = '0, rs2 = '0, dest = '0;
  logic mr = 1'b0, br = 1'b0, busy = 1'b0;
  int n_chk = 0, n_fail = 0;
  int lsc[2] = '{1, 3};
  int rem[2] = '{0, 0};
  bit wt[2] = '{1'b0, 1'b0};
  int sc[2] = '{0, 0};
  int fc[2] = '{0, 0};
  logic [7:0]  ov[2];
  logic [31:0] osc[2], ofc[2];
  logic [6:0]  ops[10];
  always #5 clk = ~clk;
  hazard_stall_control_if a1 ();
  hazard_stall_control_if a3 ();
  hazard_stall_control #(.LOAD_STALL_CYCLES(1)) dut1 (.clk(clk), .reset(rst), .hs(a1));
  hazard_stall_control #(.LOAD_STALL_CYCLES(3)) dut3 (.clk(clk), .reset(rst), .hs(a3));
  assign a1.if_id_opcode_ip = op;    assign a3.if_id_opcode_ip = op;
  assign a1.if_id_rs1_ip = rs1;      assign a3.if_id_rs1_ip = rs1;
  assign a1.if_id_rs2_ip = rs2;      assign a3.if_id_rs2_ip = rs2;
  assign a1.id_ex_mem_read_ip = mr;  assign a3.id_ex_mem_read_ip = mr;
  assign a1.id_ex_dest_ip = dest;    assign a3.id_ex_dest_ip = dest;
  assign a1.ex_branch_taken_ip = br; assign a3.ex_branch_taken_ip = br;
  assign a1.mem_busy_ip = busy;      assign a3.mem_busy_ip = busy;
  assign ov[0] = {a1.pc_write_en_op, a1.if_id_write_en_op, a1.id_ex_write_en_op,
                  a1.ex_mem_write_en_op, a1.if_id_flush_op, a1.id_ex_bubble_op, a1.hazard_state_op};
  assign ov[1] = {a3.pc_write_en_op, a3.if_id_write_en_op, a3.id_ex_write_en_op,
                  a3.ex_mem_write_en_op, a3.if_id_flush_op, a3.id_ex_bubble_op, a3.hazard_state_op};
  assign osc[0] = a1.stall_count_op;  assign osc[1] = a3.stall_count_op;
  assign ofc[0] = a1.flush_count_op;  assign ofc[1] = a3.flush_count_op;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic set(input logic [6:0] o, input logic [4:0] s1, input logic [4:0] s2, input logic m,
                     input logic [4:0] d, input logic b, input logic bz, input logic r);
    op = o; rs1 = s1; rs2 = s2; mr = m; dest = d; br = b; busy = bz; rst = r;
  endtask
  // Model: rem = stall cycles still owed, wt = frozen by memory outside a load stall.
  task automatic cycle();
    logic u1, u2, lu;
    logic [7:0] ev;
    int er;
    bit ew;
    #1;
    u2 = op inside {OPCODE_OP, OPCODE_STORE, OPCODE_BRANCH};
    u1 = u2 || (op inside {OPCODE_OPIMM, OPCODE_LOAD, OPCODE_JALR});
    lu = mr && dest != 0 && ((u1 && dest == rs1) || (u2 && dest == rs2));
    for (int k = 0; k < 2; k++) begin
      er = rst ? 0 : rem[k];
      ew = rst ? 1'b0 : wt[k];
      if (busy) ev[7:2] = 6'b000000;
      else if (br) ev[7:2] = 6'b111111;
      else if (er > 0 || lu) ev[7:2] = 6'b001101;
      else ev[7:2] = 6'b111100;
      ev[1:0] = er > 0 ? 2'd1 : ew ? 2'd2 : 2'd0;
      chk($sformatf("ctl_L%0d", lsc[k]), 32'(ov[k]), 32'(ev));
      chk($sformatf("stall_cnt_L%0d", lsc[k]), osc[k], 32'(sc[k]));
      chk($sformatf("flush_cnt_L%0d", lsc[k]), ofc[k], 32'(fc[k]));
      if (rst) begin
        rem[k] = 0; wt[k] = 1'b0; sc[k] = 0; fc[k] = 0;
      end else begin
        sc[k] += !ev[7];
        fc[k] += ev[3];
        if (busy) begin
          if (er == 0) wt[k] = 1'b1;
        end else begin
          wt[k] = 1'b0;
          if (br) rem[k] = 0;
          else if (er > 0) rem[k] = er - 1;
          else if (lu) rem[k] = lsc[k] - 1;
        end
      end
    end
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set(OPCODE_LUI, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      cycle();
    end
  endtask
  task automatic do_reset();
    set(OPCODE_LUI, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    cycle();
  endtask
  initial begin
    ops = '{OPCODE_OP, OPCODE_OPIMM, OPCODE_LOAD, OPCODE_STORE, OPCODE_BRANCH,
            OPCODE_JALR, OPCODE_JAL, OPCODE_LUI, OPCODE_AUIPC, 7'h7F};
    @(negedge clk);
    @(negedge clk);
    do_reset();
    // single load-use hazard
    set(OPCODE_OP, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0); cycle();
    idle(3);
    chk("lu_stall_L1", osc[0], 32'd1);
    chk("lu_stall_L3", osc[1], 32'd3);
    // x0 and unused-source cases never stall
    do_reset();
    set(OPCODE_OP, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0); cycle();
    set(OPCODE_LUI, 5'd5, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0); cycle();
    set(OPCODE_STORE, 5'd1, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0); cycle();
    idle(3);
    chk("no_stall_L1", osc[0], 32'd1);
    chk("no_stall_L3", osc[1], 32'd3);
    // branch beats load-use
    do_reset();
    set(OPCODE_OP, 5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0); cycle();
    idle(2);
    chk("br_flush_L3", ofc[1], 32'd1);
    chk("br_stall_L3", osc[1], 32'd0);
    // memory freeze in the middle of a load stall
    do_reset();
    set(OPCODE_OP, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0); cycle();
    for (int i = 0; i < 4; i++) begin
      set(OPCODE_OP, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); cycle();
    end
    idle(3);
    chk("busy_stall_L3", osc[1], 32'd7);
    chk("busy_stall_L1", osc[0], 32'd5);
    // reset out of MEM_WAIT
    set(OPCODE_LUI, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); cycle();
    chk("memwait_state_L1", 32'(ov[0][1:0]), 32'd2);
    cycle();
    do_reset();
    chk("rst_state_L1", 32'(ov[0][1:0]), 32'd0);
    chk("rst_stall_L1", osc[0], 32'd0);
    chk("rst_flush_L3", ofc[1], 32'd0);
    for (int i = 0; i < 800; i++) begin
      set(ops[$urandom_range(0, 9)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom_range(0, 9) == 0,
          $urandom_range(0, 6) == 0, $urandom_range(0, 49) == 0);
      cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_stall_control.md
HAZARD_STALL_CONTROL -- requirements
Module: hazard_stall_control

Interface
REQ-001 Parameter LOAD_STALL_CYCLES, default 1, number of stall cycles per load-use hazard (legal 1..3).
REQ-002 clk  input  1  core clock; all state updates on rising edge.
REQ-003 reset  input  1  reset; synchronous and active-high.
REQ-004 if_id_opcode_ip  input  7  opcode of instruction in IF/ID (decode stage).
REQ-005 if_id_rs1_ip / if_id_rs2_ip  input  5 each  source register fields of decode instruction.
REQ-006 id_ex_mem_read_ip  input  1  ID/EX instruction is a load.
REQ-007 id_ex_dest_ip  input  5  ID/EX destination register.
REQ-008 ex_branch_taken_ip  input  1  branch/jump resolved taken in EX this cycle.
REQ-009 mem_busy_ip  input  1  data memory not ready; MEM stage cannot complete.
REQ-010 pc_write_en_op  output  1  PC update enable.
REQ-011 if_id_write_en_op  output  1  IF/ID register load enable.
REQ-012 id_ex_write_en_op / ex_mem_write_en_op  output  1 each  pipeline register load enables.
REQ-013 if_id_flush_op  output  1  clear IF/ID to NOP.
REQ-014 id_ex_bubble_op  output  1  load NOP into ID/EX.
REQ-015 hazard_state_op  output  2  current FSM state (hazard_state enum).
REQ-016 stall_count_op / flush_count_op  output  32 each  performance counters.

Function
REQ-017 Source usage: OPCODE_OP, OPCODE_STORE, OPCODE_BRANCH use rs1 and rs2; OPCODE_OPIMM, OPCODE_LOAD, OPCODE_JALR use rs1 only; OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL and unknown opcodes use none.
REQ-018 load_use = id_ex_mem_read_ip and id_ex_dest_ip != 0 and id_ex_dest_ip equals a used source register.
REQ-019 FSM states RUN(0), LOAD_STALL(1), MEM_WAIT(2); outputs are combinational in state and inputs.
REQ-020 Default outputs (no event): all write enables 1, if_id_flush_op 0, id_ex_bubble_op 0.
REQ-021 Priority in RUN and LOAD_STALL: mem_busy_ip > ex_branch_taken_ip > load stall.
REQ-022 mem_busy_ip=1 (any state): all four write enables 0, flush 0, bubble 0; RUN -> MEM_WAIT; LOAD_STALL stays with counter held.
REQ-023 MEM_WAIT with mem_busy_ip=0: outputs and next state evaluated exactly as RUN.
REQ-024 ex_branch_taken_ip=1 (not busy): if_id_flush_op=1, id_ex_bubble_op=1, pc_write_en_op=1; next state RUN; aborts any LOAD_STALL.
REQ-025 RUN with load_use (not busy, no branch): pc_write_en_op=0, if_id_write_en_op=0, id_ex_bubble_op=1; if LOAD_STALL_CYCLES>1 enter LOAD_STALL with counter = LOAD_STALL_CYCLES-1, else stay RUN.
REQ-026 LOAD_STALL (not busy, no branch): same stall outputs as REQ-025 regardless of load_use; counter decrements; exit to RUN when counter is 1 at the edge.
REQ-027 Total load-use stall = exactly LOAD_STALL_CYCLES non-busy cycles.
REQ-028 stall_count_op increments each cycle pc_write_en_op=0; flush_count_op increments each cycle if_id_flush_op=1; both saturate at 0xFFFF_FFFF.

Reset
REQ-029 reset=1 at an edge: state RUN, stall counter 0, both perf counters 0, from any state including mid-stall.
REQ-030 While reset=1, outputs follow RUN rules from the reset state; counters do not increment.

Structure
REQ-031 hazard_state enum and LOAD_STALL_CYCLES range constants reside in CORE_PKG; opcode constants reused from CORE_PKG.
REQ-032 Source-usage decode (REQ-017) is sub-module hazard_rs_usage (combinational, opcode in, rs1_used/rs2_used out).

Verification
REQ-033 id_ex_mem_read=1, dest=5, OPCODE_OP rs1=5 -> one cycle pc_we=0, if_id_we=0, bubble=1, stall_count=1; next cycle default outputs.
REQ-034 LOAD_STALL_CYCLES=3, same stimulus -> 3 stall cycles, hazard_state 1 on cycles 2-3, then 0; stall_count=3.
REQ-035 dest=0 with rs1=0; LUI with rs1 field=5 and dest=5 -> no stall.
REQ-036 branch_taken=1 together with load_use -> flush=1, bubble=1, pc_we=1, flush_count=1, stall_count unchanged.
REQ-037 LOAD_STALL_CYCLES=3, mem_busy=1 for 4 cycles after first stall cycle -> 4 freeze cycles, then 2 remaining stall cycles, stall_count=7.
REQ-038 reset during MEM_WAIT -> next cycle hazard_state=0, both counters 0.
